// File: rtl/spi_cmd_ctrl_pkg.sv
// Shared definitions for the SPI command controller.
// State encodings and the channel address tags.
package spi_cmd_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_GRANT     = 2'd1,
    S_WAIT_POLL = 2'd2,
    S_ACK       = 2'd3
  } state_t;

  localparam logic [7:0] TAG_BASE  = 8'h80;
  localparam logic [7:0] TAG_EMPTY = 8'h00;

  function automatic logic [7:0] tag_of(input logic [1:0] idx);
    return TAG_BASE | {6'b0, idx};
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl_rr.sv
// Four-way round-robin picker.
// Returns the first set request at or above ptr, wrapping 3->0.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] grant,
  output logic       valid
);

  logic [1:0] idx;

  // Scan from the farthest offset down so the nearest hit wins last
  always_comb begin
    grant = 2'd0;
    valid = 1'b0;
    idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: channel arbitration toward the PC,
// poll handling with timeout, register writes and error counting.
module spi_cmd_ctrl
  import spi_cmd_ctrl_pkg::*;
#(
  parameter logic [7:0]  READ_REQ_ADDR = 8'hFF,
  parameter logic [15:0] TIMEOUT       = 16'd1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FRAME_VALID,
  input  logic [7:0]  RX_ADDR,
  input  logic [7:0]  RX_DATA,
  input  logic [3:0]  CH_REQ,
  input  logic [31:0] CH_DATA,
  output logic [7:0]  TX_DATA,
  output logic [7:0]  TX_ADDR,
  output logic        SEND_REQ,
  output logic [3:0]  CH_ACK,
  output logic        REG_WE,
  output logic [6:0]  REG_ADDR,
  output logic [7:0]  REG_WDATA,
  output logic [7:0]  ERR_CNT
);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  ptr;
  logic [1:0]  gnt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [1:0]  arb_idx;
  logic        arb_vld;
  logic        poll;
  logic        err_frame;
  logic        wr_frame;
  logic        tmo;
  logic [8:0]  err_sum;

  rr_arbiter4 u_arb (
    .req   (CH_REQ),
    .ptr   (ptr),
    .grant (arb_idx),
    .valid (arb_vld)
  );

  assign poll      = FRAME_VALID && (RX_ADDR == READ_REQ_ADDR);
  assign wr_frame  = FRAME_VALID && !RX_ADDR[7];
  assign err_frame = FRAME_VALID && RX_ADDR[7] && !poll;
  assign cnt_nxt   = cnt + 16'd1;
  // A poll arriving on the expiry cycle still wins
  assign tmo       = (state == S_WAIT_POLL) && !poll
                     && (cnt_nxt == TIMEOUT);
  assign err_sum   = {1'b0, ERR_CNT} + 9'(err_frame) + 9'(tmo);

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (|CH_REQ) state_nxt = S_GRANT;
      S_GRANT:     state_nxt = arb_vld ? S_WAIT_POLL : S_IDLE;
      S_WAIT_POLL: begin
        if (poll)     state_nxt = S_ACK;
        else if (tmo) state_nxt = S_IDLE;
      end
      S_ACK:       state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // State-decoded handshake outputs
  always_comb begin
    SEND_REQ = (state == S_WAIT_POLL);
    CH_ACK   = (state == S_ACK) ? (4'b0001 << gnt) : 4'b0000;
  end

  // Grant latch, TX bytes, pointer and timeout counter
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ptr     <= 2'd0;
      gnt     <= 2'd0;
      cnt     <= 16'd0;
      TX_ADDR <= TAG_EMPTY;
      TX_DATA <= 8'h00;
    end else begin
      case (state)
        S_GRANT: begin
          cnt <= 16'd0;
          if (arb_vld) begin
            gnt     <= arb_idx;
            TX_ADDR <= tag_of(arb_idx);
            TX_DATA <= CH_DATA[{arb_idx, 3'b000} +: 8];
          end
        end
        S_WAIT_POLL: begin
          cnt <= cnt_nxt;
          if (poll || tmo) begin
            TX_ADDR <= TAG_EMPTY;
            TX_DATA <= 8'h00;
          end
          if (tmo) ptr <= gnt + 2'd1;
        end
        S_ACK:   ptr <= gnt + 2'd1;
        default: ;
      endcase
    end
  end

  // Register write strobe, one cycle after the frame
  always_ff @(posedge CLK) begin
    if (!RST) begin
      REG_WE    <= 1'b0;
      REG_ADDR  <= 7'd0;
      REG_WDATA <= 8'd0;
    end else begin
      REG_WE <= wr_frame;
      if (wr_frame) begin
        REG_ADDR  <= RX_ADDR[6:0];
        REG_WDATA <= RX_DATA;
      end
    end
  end

  // Saturating error counter
  always_ff @(posedge CLK) begin
    if (!RST)            ERR_CNT <= 8'd0;
    else if (err_sum[8]) ERR_CNT <= 8'hFF;
    else                 ERR_CNT <= err_sum[7:0];
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl.
// Inputs driven and outputs sampled on the falling edge.
module tb_spi_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        FRAME_VALID;
  logic [7:0]  RX_ADDR;
  logic [7:0]  RX_DATA;
  logic [3:0]  CH_REQ;
  logic [31:0] CH_DATA;
  logic [7:0]  TX_DATA;
  logic [7:0]  TX_ADDR;
  logic        SEND_REQ;
  logic [3:0]  CH_ACK;
  logic        REG_WE;
  logic [6:0]  REG_ADDR;
  logic [7:0]  REG_WDATA;
  logic [7:0]  ERR_CNT;

  int nchk = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  spi_cmd_ctrl #(
    .READ_REQ_ADDR (8'hFF),
    .TIMEOUT       (16'd10)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .FRAME_VALID (FRAME_VALID),
    .RX_ADDR     (RX_ADDR),
    .RX_DATA     (RX_DATA),
    .CH_REQ      (CH_REQ),
    .CH_DATA     (CH_DATA),
    .TX_DATA     (TX_DATA),
    .TX_ADDR     (TX_ADDR),
    .SEND_REQ    (SEND_REQ),
    .CH_ACK      (CH_ACK),
    .REG_WE      (REG_WE),
    .REG_ADDR    (REG_ADDR),
    .REG_WDATA   (REG_WDATA),
    .ERR_CNT     (ERR_CNT)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d);
    FRAME_VALID = 1'b1;
    RX_ADDR     = a;
    RX_DATA     = d;
    tick();
    FRAME_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RST         = 1'b0;
    FRAME_VALID = 1'b0;
    RX_ADDR     = 8'h00;
    RX_DATA     = 8'h00;
    CH_REQ      = 4'b0000;
    CH_DATA     = 32'h44332211;
    repeat (3) tick();
    check("rst_send", {31'd0, SEND_REQ}, 32'd0);
    check("rst_txa", {24'd0, TX_ADDR}, 32'h00);
    check("rst_ack", {28'd0, CH_ACK}, 32'd0);
    check("rst_err", {24'd0, ERR_CNT}, 32'd0);
    check("rst_we", {31'd0, REG_WE}, 32'd0);
    RST = 1'b1;

    // Round robin: 0101 from ptr 0 grants 0 then 2
    CH_REQ = 4'b0101;
    tick();
    check("lat_send0", {31'd0, SEND_REQ}, 32'd0);
    tick();
    check("g0_send", {31'd0, SEND_REQ}, 32'd1);
    check("g0_txa", {24'd0, TX_ADDR}, 32'h80);
    check("g0_txd", {24'd0, TX_DATA}, 32'h11);
    frame(8'h12, 8'hA5);
    check("wr_we", {31'd0, REG_WE}, 32'd1);
    check("wr_addr", {25'd0, REG_ADDR}, 32'h12);
    check("wr_data", {24'd0, REG_WDATA}, 32'hA5);
    check("wr_send", {31'd0, SEND_REQ}, 32'd1);
    tick();
    check("wr_we_pulse", {31'd0, REG_WE}, 32'd0);
    check("wr_txa_hold", {24'd0, TX_ADDR}, 32'h80);
    frame(8'hFF, 8'h00);
    check("g0_ack", {28'd0, CH_ACK}, 32'h1);
    check("g0_ack_send", {31'd0, SEND_REQ}, 32'd0);
    check("g0_ack_txa", {24'd0, TX_ADDR}, 32'h00);
    tick();
    check("g0_ack_pulse", {28'd0, CH_ACK}, 32'h0);
    tick();
    tick();
    check("g2_txa", {24'd0, TX_ADDR}, 32'h82);
    check("g2_txd", {24'd0, TX_DATA}, 32'h33);
    frame(8'hFF, 8'h00);
    check("g2_ack", {28'd0, CH_ACK}, 32'h4);
    CH_REQ = 4'b0000;
    tick();

    // Timeout on channel 3, then pointer moves to 0
    CH_REQ = 4'b1001;
    tick();
    tick();
    check("g3_txa", {24'd0, TX_ADDR}, 32'h83);
    repeat (9) tick();
    check("tmo_pre_send", {31'd0, SEND_REQ}, 32'd1);
    check("tmo_pre_ack", {28'd0, CH_ACK}, 32'h0);
    tick();
    check("tmo_send", {31'd0, SEND_REQ}, 32'd0);
    check("tmo_ack", {28'd0, CH_ACK}, 32'h0);
    check("tmo_err", {24'd0, ERR_CNT}, 32'd1);
    check("tmo_txa", {24'd0, TX_ADDR}, 32'h00);
    tick();
    tick();
    check("tmo_next_txa", {24'd0, TX_ADDR}, 32'h80);
    frame(8'hFF, 8'h00);
    check("tmo_next_ack", {28'd0, CH_ACK}, 32'h1);
    CH_REQ = 4'b0000;
    tick();

    // Poll while idle, error frames, saturation
    frame(8'hFF, 8'h00);
    check("idle_poll_ack", {28'd0, CH_ACK}, 32'h0);
    check("idle_poll_txa", {24'd0, TX_ADDR}, 32'h00);
    check("idle_poll_err", {24'd0, ERR_CNT}, 32'd1);
    check("idle_poll_send", {31'd0, SEND_REQ}, 32'd0);
    frame(8'h90, 8'h55);
    check("bad_err", {24'd0, ERR_CNT}, 32'd2);
    check("bad_we", {31'd0, REG_WE}, 32'd0);
    for (int i = 0; i < 300; i++) frame(8'h90, 8'h00);
    check("sat_err", {24'd0, ERR_CNT}, 32'hFF);
    frame(8'h7F, 8'h3C);
    check("idle_wr_addr", {25'd0, REG_ADDR}, 32'h7F);
    check("idle_wr_data", {24'd0, REG_WDATA}, 32'h3C);

    // Reset during WAIT_POLL
    CH_REQ = 4'b0010;
    tick();
    tick();
    check("g1_txa", {24'd0, TX_ADDR}, 32'h81);
    RST = 1'b0;
    tick();
    check("mrst_send", {31'd0, SEND_REQ}, 32'd0);
    check("mrst_txa", {24'd0, TX_ADDR}, 32'h00);
    check("mrst_txd", {24'd0, TX_DATA}, 32'h00);
    check("mrst_ack", {28'd0, CH_ACK}, 32'h0);
    check("mrst_err", {24'd0, ERR_CNT}, 32'h00);
    check("mrst_raddr", {25'd0, REG_ADDR}, 32'h00);
    check("mrst_rdata", {24'd0, REG_WDATA}, 32'h00);
    RST    = 1'b1;
    CH_REQ = 4'b1000;
    tick();
    tick();
    check("g3b_txa", {24'd0, TX_ADDR}, 32'h83);
    check("g3b_txd", {24'd0, TX_DATA}, 32'h44);
    CH_REQ = 4'b0000;
    tick();
    check("drop_send", {31'd0, SEND_REQ}, 32'd1);
    frame(8'hFF, 8'h00);
    check("drop_ack", {28'd0, CH_ACK}, 32'h8);
    tick();
    check("drop_ack_pulse", {28'd0, CH_ACK}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 Parameter READ_REQ_ADDR, default 8'hFF, is the SPI address of a PC poll frame.
REQ-002 Parameter TIMEOUT, default 16'd1000, is the maximum number of CLK cycles a granted word waits for a poll.
REQ-003 CLK  in  1  single system clock; all logic on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-low.
REQ-005 FRAME_VALID  in  1  one-cycle pulse at end of an SPI frame (SS rising edge).
REQ-006 RX_ADDR  in  8  address byte of the completed frame; valid when FRAME_VALID=1.
REQ-007 RX_DATA  in  8  data byte of the completed frame; valid when FRAME_VALID=1.
REQ-008 CH_REQ  in  4  per-channel level request to send one status word to PC; held until that channel's CH_ACK.
REQ-009 CH_DATA  in  32  four 8-bit status words; channel n occupies bits [8n+7:8n].
REQ-010 TX_DATA  out  8  data byte presented to the SPI slave for the next frame.
REQ-011 TX_ADDR  out  8  address byte presented to the SPI slave: 8'h80|n when channel n is granted, else 8'h00.
REQ-012 SEND_REQ  out  1  level; high while a granted word awaits a poll.
REQ-013 CH_ACK  out  4  one-cycle pulse to the channel whose word was polled.
REQ-014 REG_WE  out  1  one-cycle register write strobe.
REQ-015 REG_ADDR  out  7  register write address.
REQ-016 REG_WDATA  out  8  register write data.
REQ-017 ERR_CNT  out  8  saturating error count.

Function
REQ-018 FSM states: IDLE, GRANT, WAIT_POLL, ACK.
REQ-019 IDLE -> GRANT when CH_REQ != 0; otherwise stay.
REQ-020 GRANT: round-robin pick first set CH_REQ bit at or above pointer PTR, wrapping 3->0; latch grant index G, TX_DATA=CH_DATA[G], TX_ADDR=8'h80|G; go to WAIT_POLL next cycle.
REQ-021 WAIT_POLL: SEND_REQ=1; TX_DATA/TX_ADDR held stable; timeout counter increments each cycle.
REQ-022 WAIT_POLL -> ACK on FRAME_VALID with RX_ADDR==READ_REQ_ADDR.
REQ-023 ACK (one cycle): CH_ACK[G]=1, SEND_REQ=0, PTR=G+1 mod 4, TX_ADDR=8'h00, TX_DATA=8'h00; then IDLE.
REQ-024 Request-to-SEND_REQ latency is 2 cycles from CH_REQ rising in IDLE; poll-to-CH_ACK latency is 1 cycle.
REQ-025 Timeout: counter reaching TIMEOUT in WAIT_POLL -> IDLE without CH_ACK, PTR=G+1, ERR_CNT+1, TX cleared to 8'h00.
REQ-026 Poll frame in IDLE or GRANT is ignored (no error); the PC then reads TX_ADDR=8'h00 meaning "empty".
REQ-027 Write frame: FRAME_VALID with RX_ADDR[7]=0 -> REG_WE=1, REG_ADDR=RX_ADDR[6:0], REG_WDATA=RX_DATA on the next cycle, in every FSM state.
REQ-028 Frame with RX_ADDR[7]=1 and RX_ADDR!=READ_REQ_ADDR: no write, no state change, ERR_CNT+1.
REQ-029 ERR_CNT saturates at 8'hFF.
REQ-030 CH_REQ[G] dropping during WAIT_POLL does not abort; the word is still delivered and acknowledged.
REQ-031 REG_WE and CH_ACK are never high for more than one consecutive cycle per frame.

Reset
REQ-032 RST=0 sampled on a CLK edge: state IDLE, PTR=0, counter=0, all outputs 0, ERR_CNT=0, including mid-WAIT_POLL (granted word dropped, no CH_ACK).

Structure
REQ-033 FSM state encodings, the 8'h80 channel-tag base and the "empty" tag 8'h00 live in a shared defines package used by the SPI path.
REQ-034 The round-robin picker is one sub-module, rr_arbiter4 (inputs req[3:0], ptr[1:0]; outputs grant index, valid).

Verification
REQ-035 CH_REQ=4'b0101, PTR=0 -> grant 0, TX_ADDR=8'h80; poll -> CH_ACK=4'b0001; then grant 2, TX_ADDR=8'h82.
REQ-036 Frame RX_ADDR=8'h12, RX_DATA=8'hA5 during WAIT_POLL -> REG_WE pulse, REG_ADDR=7'h12, REG_WDATA=8'hA5; SEND_REQ stays 1.
REQ-037 TIMEOUT=10, grant with no poll -> after 10 cycles SEND_REQ=0, no CH_ACK, ERR_CNT=1, next grant goes to the next channel.
REQ-038 Poll with CH_REQ=0 -> no CH_ACK, TX_ADDR=8'h00, ERR_CNT unchanged; RX_ADDR=8'h90 frame -> ERR_CNT+1; 300 such frames -> ERR_CNT=8'hFF.
REQ-039 RST=0 asserted in WAIT_POLL -> next cycle all outputs 0, IDLE; after release CH_REQ=4'b1000 -> grant 3 (round-robin search starts at PTR=0).
